// File: rtl/axi_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_wr_arbiter
//   Shares one AXI write master between two independent write sources.
//   Round-robin arbitration at burst granularity: the granted source's
//   address/length is issued on the master's request interface, then that
//   source's write-data stream is multiplexed through until its last beat.
//
// Optional feature (macro WR_ARB_LEN_CHK_EN):
//   Beat counter checks each burst against its length. A missing last is
//   forced on the final beat. A premature last is flagged. Both set a sticky
//   len_err. Without the macro, len_err is tied 0.
//
// Ports:
//   axi_clk, reset                  clock, async active-low reset
//   chN_req/addr/len, chN_ack       source burst request and address accept
//   chN_w_data/valid/last/ready     source write-data stream
//   chN_done                        source last beat accepted
//   wr_aw_req_en/addr/burst_len     address request to the master
//   wr_aw_ready                     master address accept
//   wr_w_data/valid/last/ready      muxed write data to the master
//   busy                            arbiter not in IDLE
//   len_err                         sticky beat-count error
// -----------------------------------------------------------------------------
module axi_wr_arbiter #(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      axi_clk,
  input  logic                      reset,

  input  logic                      ch0_req,
  input  logic [AXI_ADDR_WIDTH-1:0] ch0_addr,
  input  logic [7:0]                ch0_len,
  output logic                      ch0_ack,
  input  logic [AXI_DATA_WIDTH-1:0] ch0_w_data,
  input  logic                      ch0_w_valid,
  input  logic                      ch0_w_last,
  output logic                      ch0_w_ready,
  output logic                      ch0_done,

  input  logic                      ch1_req,
  input  logic [AXI_ADDR_WIDTH-1:0] ch1_addr,
  input  logic [7:0]                ch1_len,
  output logic                      ch1_ack,
  input  logic [AXI_DATA_WIDTH-1:0] ch1_w_data,
  input  logic                      ch1_w_valid,
  input  logic                      ch1_w_last,
  output logic                      ch1_w_ready,
  output logic                      ch1_done,

  output logic                      wr_aw_req_en,
  output logic [AXI_ADDR_WIDTH-1:0] wr_aw_addr,
  output logic [7:0]                wr_aw_burst_len,
  input  logic                      wr_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0] wr_w_data,
  output logic                      wr_w_valid,
  output logic                      wr_w_last,
  input  logic                      wr_w_ready,

  output logic                      busy,
  output logic                      len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;   // 0 = ch0, 1 = ch1
  logic   last_served;        // channel that completed the previous burst

  logic                      in_data;
  logic                      aw_hs;
  logic                      accept;
  logic                      beat_end;
  logic                      src_last;
  logic                      sel_valid;
  logic                      sel_last;
  logic [AXI_DATA_WIDTH-1:0] sel_data;

  // ---------------------------------------------------------------------------
  // Next-state and grant decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_nxt = state;
    grant_nxt = grant;
    unique case (state)
      IDLE: begin
        if (ch0_req && ch1_req) begin
          // Tie: serve the channel that did not go last.
          grant_nxt = ~last_served;
          state_nxt = ADDR;
        end else if (ch0_req) begin
          grant_nxt = 1'b0;
          state_nxt = ADDR;
        end else if (ch1_req) begin
          grant_nxt = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: if (wr_aw_ready) state_nxt = DATA;
      DATA: if (beat_end)    state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, grant, pointer and captured address/length
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!reset) begin
      state           <= IDLE;
      grant           <= 1'b0;
      last_served     <= 1'b1;   // ch0 wins the first tie
      wr_aw_addr      <= '0;
      wr_aw_burst_len <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      // Address/length sampled only at grant; later changes are ignored.
      if (state == IDLE && state_nxt == ADDR) begin
        wr_aw_addr      <= grant_nxt ? ch1_addr : ch0_addr;
        wr_aw_burst_len <= grant_nxt ? ch1_len  : ch0_len;
      end
      if (state == DONE) last_served <= grant;
    end
  end

  // ---------------------------------------------------------------------------
  // Data path mux: zero latency, quiet outside DATA
  // ---------------------------------------------------------------------------
  assign in_data   = (state == DATA);
  assign sel_valid = grant ? ch1_w_valid : ch0_w_valid;
  assign sel_last  = grant ? ch1_w_last  : ch0_w_last;
  assign sel_data  = grant ? ch1_w_data  : ch0_w_data;

  assign wr_w_valid = in_data & sel_valid;
  assign wr_w_data  = in_data ? sel_data : '0;
  assign src_last   = in_data & sel_last;
  assign accept     = wr_w_valid & wr_w_ready;
  assign beat_end   = accept & wr_w_last;

  assign aw_hs        = (state == ADDR) & wr_aw_ready;
  assign wr_aw_req_en = (state == ADDR);
  assign busy         = (state != IDLE);

  assign ch0_ack     = aw_hs & ~grant;
  assign ch1_ack     = aw_hs &  grant;
  assign ch0_w_ready = in_data & ~grant & wr_w_ready;
  assign ch1_w_ready = in_data &  grant & wr_w_ready;
  assign ch0_done    = beat_end & ~grant;
  assign ch1_done    = beat_end &  grant;

`ifdef WR_ARB_LEN_CHK_EN
  // ---------------------------------------------------------------------------
  // Beat-count checking
  // ---------------------------------------------------------------------------
  logic [7:0] beat_cnt;
  logic       at_len;

  assign at_len    = (beat_cnt == wr_aw_burst_len);
  // Final beat by count terminates the burst even without source last.
  assign wr_w_last = src_last | (in_data & at_len);

  always_ff @(posedge axi_clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      if (aw_hs)       beat_cnt <= '0;
      else if (accept) beat_cnt <= beat_cnt + 8'd1;
      if (accept && ((at_len && !src_last) || (src_last && !at_len)))
        len_err <= 1'b1;
    end
  end
`else
  assign wr_w_last = src_last;
  assign len_err   = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_arbiter
//   Scoreboard bench for axi_wr_arbiter. Directed bursts push the expected
//   address requests and data beats (in expected grant order) into queues; a
//   monitor on the falling edge pops and compares on every master handshake.
// -----------------------------------------------------------------------------
module tb_axi_wr_arbiter;

  localparam int DW = 128;
  localparam int AW = 32;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [7:0]  len;
    int          cycles;   // expected wr_aw_req_en high cycles, 0 = any
  } aw_exp_t;

  typedef struct {
    int          ch;
    logic [DW-1:0] data;
    logic        last;
  } w_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]    req = '0;
  logic [AW-1:0] addr_s [2];
  logic [7:0]    len_s  [2];
  logic [DW-1:0] data_s [2];
  logic [1:0]    valid_s = '0;
  logic [1:0]    last_s  = '0;
  logic [1:0]    ack, wrdy, done;

  logic          aw_req_en;
  logic [AW-1:0] aw_addr;
  logic [7:0]    aw_len;
  logic          aw_ready = 1'b0;
  logic [DW-1:0] w_data;
  logic          w_valid, w_last;
  logic          w_ready = 1'b1;
  logic          busy, len_err;

  int tests = 0;
  int failures = 0;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];

  int aw_delay = 0;   // cycles of wr_aw_req_en before wr_aw_ready
  int wr_mode  = 0;   // 0: ready always 1, 1: toggle, 2: driven by test
  int aw_wait  = 0;
  int aw_cycles = 0;
  int done_age = 0;

  axi_wr_arbiter #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .axi_clk(clk), .reset(rst_n),
    .ch0_req(req[0]), .ch0_addr(addr_s[0]), .ch0_len(len_s[0]), .ch0_ack(ack[0]),
    .ch0_w_data(data_s[0]), .ch0_w_valid(valid_s[0]), .ch0_w_last(last_s[0]),
    .ch0_w_ready(wrdy[0]), .ch0_done(done[0]),
    .ch1_req(req[1]), .ch1_addr(addr_s[1]), .ch1_len(len_s[1]), .ch1_ack(ack[1]),
    .ch1_w_data(data_s[1]), .ch1_w_valid(valid_s[1]), .ch1_w_last(last_s[1]),
    .ch1_w_ready(wrdy[1]), .ch1_done(done[1]),
    .wr_aw_req_en(aw_req_en), .wr_aw_addr(aw_addr), .wr_aw_burst_len(aw_len),
    .wr_aw_ready(aw_ready),
    .wr_w_data(w_data), .wr_w_valid(w_valid), .wr_w_last(w_last), .wr_w_ready(w_ready),
    .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [31:0] base, input int b);
    logic [31:0] w;
    w = base + 32'(b);
    return {4{w}};
  endfunction

  // Master address-ready model: ready after aw_delay cycles of request.
  always @(posedge clk) begin
    #1;
    if (aw_req_en) begin
      aw_ready = (aw_wait == aw_delay);
      aw_wait++;
    end else begin
      aw_ready = 1'b0;
      aw_wait  = 0;
    end
    if (wr_mode == 0)      w_ready = 1'b1;
    else if (wr_mode == 1) w_ready = ~w_ready;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_age  = 0;
      aw_cycles = 0;
    end else begin
      aw_exp_t ea;
      w_exp_t  ew;
      if (done_age == 2) begin
        check("busy_low_after_done", busy, 0);
        done_age = 0;
      end else if (done_age == 1) begin
        check("busy_in_done", busy, 1);
        done_age = 2;
      end
      if (aw_req_en) aw_cycles++;
      if (aw_req_en && aw_ready) begin
        if (aw_q.size() == 0) begin
          check("unexpected_aw", 1, 0);
        end else begin
          ea = aw_q.pop_front();
          check("aw_addr", aw_addr, ea.addr);
          check("aw_len", aw_len, ea.len);
          check("ack_granted", ack[ea.ch], 1);
          check("ack_other", ack[1-ea.ch], 0);
          if (ea.cycles != 0) check("aw_req_cycles", aw_cycles, ea.cycles);
        end
        aw_cycles = 0;
      end else if (ack != 2'b00) begin
        check("ack_without_handshake", ack, 0);
      end
      if (w_valid && w_ready) begin
        if (w_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          ew = w_q.pop_front();
          check("w_data", w_data, ew.data);
          check("w_last", w_last, ew.last);
          check("w_ready_granted", wrdy[ew.ch], 1);
          check("w_ready_other", wrdy[1-ew.ch], 0);
          check("done_pulse", done[ew.ch], ew.last);
        end
      end
      if (done != 2'b00) done_age = 1;
    end
  end

  task automatic expect_burst(input int ch, input logic [31:0] a, input logic [7:0] l,
                              input int nbeats, input logic [31:0] base, input int cyc);
    aw_q.push_back('{ch: ch, addr: a, len: l, cycles: cyc});
    for (int b = 0; b < nbeats; b++)
      w_q.push_back('{ch: ch, data: beat_data(base, b), last: (b == nbeats - 1)});
  endtask

  // Source model: request, wait for ack, stream nbeats honouring ready.
  task automatic drive(input int ch, input logic [31:0] a, input logic [7:0] l,
                       input int nbeats, input logic [31:0] base, input bit give_last);
    int n;
    @(posedge clk); #1;
    req[ch] = 1'b1; addr_s[ch] = a; len_s[ch] = l;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ack[ch]) break;
    end
    if (n == 200) begin
      check("ack_timeout", 0, 1);
      req[ch] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req[ch] = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      data_s[ch]  = beat_data(base, b);
      valid_s[ch] = 1'b1;
      last_s[ch]  = give_last && (b == nbeats - 1);
      for (n = 0; n < 200; n++) begin
        @(negedge clk);
        if (wrdy[ch]) break;
      end
      if (n == 200) begin
        check("beat_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    valid_s[ch] = 1'b0;
    last_s[ch]  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_aw_req_en"}, aw_req_en, 0);
    check({tag, "_aw_addr"}, aw_addr, 0);
    check({tag, "_aw_len"}, aw_len, 0);
    check({tag, "_w_valid"}, w_valid, 0);
    check({tag, "_w_data"}, w_data, 0);
    check({tag, "_w_last"}, w_last, 0);
    check({tag, "_ch_ack"}, ack, 0);
    check({tag, "_ch_ready"}, wrdy, 0);
    check({tag, "_ch_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_len_err"}, len_err, 0);
  endtask

  task automatic settle(input string tag);
    repeat (4) @(posedge clk);
    check({tag, "_aw_q_empty"}, aw_q.size(), 0);
    check({tag, "_w_q_empty"}, w_q.size(), 0);
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      addr_s[c] = '0; len_s[c] = '0; data_s[c] = '0;
    end
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single burst, address ready after 2 waiting cycles.
    aw_delay = 2;
    expect_burst(0, 32'h0000_1000, 8'd3, 4, 32'hA000_0000, 3);
    drive(0, 32'h0000_1000, 8'd3, 4, 32'hA000_0000, 1);
    settle("single");
    aw_delay = 0;

    // Simultaneous requests after reset: ch0 first.
    do_reset();
    expect_burst(0, 32'h0000_2000, 8'd1, 2, 32'hB000_0000, 0);
    expect_burst(1, 32'h0000_2100, 8'd1, 2, 32'hB100_0000, 0);
    fork
      drive(0, 32'h0000_2000, 8'd1, 2, 32'hB000_0000, 1);
      drive(1, 32'h0000_2100, 8'd1, 2, 32'hB100_0000, 1);
    join
    settle("tie");

    // Continuous requests: grants alternate ch0, ch1, ch0, ch1.
    expect_burst(0, 32'h0000_4000, 8'd0, 1, 32'hC000_0000, 0);
    expect_burst(1, 32'h0000_4100, 8'd2, 3, 32'hC100_0000, 0);
    expect_burst(0, 32'h0000_4200, 8'd1, 2, 32'hC200_0000, 0);
    expect_burst(1, 32'h0000_4300, 8'd0, 1, 32'hC300_0000, 0);
    fork
      begin
        drive(0, 32'h0000_4000, 8'd0, 1, 32'hC000_0000, 1);
        drive(0, 32'h0000_4200, 8'd1, 2, 32'hC200_0000, 1);
      end
      begin
        drive(1, 32'h0000_4100, 8'd2, 3, 32'hC100_0000, 1);
        drive(1, 32'h0000_4300, 8'd0, 1, 32'hC300_0000, 1);
      end
    join
    settle("alternate");

    // Backpressure: ready toggles during a 4-beat burst.
    wr_mode = 1;
    expect_burst(0, 32'h0000_5000, 8'd3, 4, 32'hD000_0000, 0);
    drive(0, 32'h0000_5000, 8'd3, 4, 32'hD000_0000, 1);
    settle("toggle");
    wr_mode = 0;

    // Reset during beat 2 of an 8-beat burst (last served before this: ch0).
    wr_mode = 2;
    aw_q.push_back('{ch: 0, addr: 32'h0000_3000, len: 8'd7, cycles: 0});
    w_q.push_back('{ch: 0, data: beat_data(32'hE000_0000, 0), last: 1'b0});
    @(posedge clk); #1;
    req[0] = 1'b1; addr_s[0] = 32'h0000_3000; len_s[0] = 8'd7;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ack[0]) break;
    end
    @(posedge clk); #1;
    req[0] = 1'b0; valid_s[0] = 1'b1; data_s[0] = beat_data(32'hE000_0000, 0);
    w_ready = 1'b1;
    @(posedge clk); #1;
    data_s[0] = beat_data(32'hE000_0000, 1);
    w_ready = 1'b0;
    @(negedge clk);
    check("mid_burst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    valid_s[0] = 1'b0;
    wr_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_q_empty", w_q.size(), 0);
    // Pointer back to reset value: tie goes to ch0.
    expect_burst(0, 32'h0000_6000, 8'd0, 1, 32'hF000_0000, 0);
    expect_burst(1, 32'h0000_6100, 8'd1, 2, 32'hF100_0000, 0);
    fork
      drive(0, 32'h0000_6000, 8'd0, 1, 32'hF000_0000, 1);
      drive(1, 32'h0000_6100, 8'd1, 2, 32'hF100_0000, 1);
    join
    settle("post_reset");

`ifdef WR_ARB_LEN_CHK_EN
    // Source never asserts last: forced on beat 3, sticky error.
    expect_burst(0, 32'h0000_7000, 8'd2, 3, 32'h7700_0000, 0);
    drive(0, 32'h0000_7000, 8'd2, 3, 32'h7700_0000, 0);
    settle("len_force");
    check("len_err_set", len_err, 1);
    repeat (5) @(posedge clk);
    check("len_err_sticky", len_err, 1);
`else
    check("len_err_tied", len_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
